// File: rtl/flash_pkg.sv
// Shared types and constants for the byte-wide NOR flash responder model.
package flash_pkg;

  // One enumeration serves both the background operation FSM
  // (INIT/IDLE/PROG_*/BUSY) and the bus read channel (IDLE/READ_*/HOLD).
  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ_WAIT,
    ST_READ_DRIVE,
    ST_HOLD,
    ST_PROG_RD,
    ST_PROG_WR,
    ST_BUSY
  } flash_state_e;

  localparam logic [7:0] ERASED      = 8'hFF;
  localparam logic [7:0] STATUS_BUSY = 8'h00;

  localparam int         DEF_ACCESS_CYCLES = 3;
  localparam int         DEF_PROG_CYCLES   = 16;
  localparam logic [7:0] DEF_PROTECT_TOP   = 8'h0F;

endpackage

// File: rtl/flash_responder_if.sv
// Flash control/address bus plus the two status outputs. The data bus is
// bidirectional and stays a plain inout on the top so the tristate lives there.
interface flash_responder_if;
  logic       NF_CE;
  logic       NF_OE;
  logic       NF_WE;
  logic       NF_RP;
  logic       NF_WP;
  logic       NF_BYTE;
  logic [7:0] NF_A;
  logic       NF_STS;
  logic       prog_err;

  modport master (
    output NF_CE, NF_OE, NF_WE, NF_RP, NF_WP, NF_BYTE, NF_A,
    input  NF_STS, prog_err
  );

  modport slave (
    input  NF_CE, NF_OE, NF_WE, NF_RP, NF_WP, NF_BYTE, NF_A,
    output NF_STS, prog_err
  );
endinterface

// File: rtl/flash_mem_array.sv
// 256x8 single-port synchronous RAM: one read or one write per cycle.
// Read data is registered; a write cycle leaves the read register unchanged.
module flash_mem_array (
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [256];

  // Single port: write when enabled, otherwise register a read of addr_i.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    else      rdata_o       <= mem_q[addr_i];
  end

endmodule

// File: rtl/flash_responder.sv
// Byte-mode parallel NOR flash responder. A background FSM handles the erase
// sweep (INIT) and byte programs; an independent read channel serves bus reads,
// returning the busy status byte whenever the background FSM is not idle.
module flash_responder
  import flash_pkg::*;
#(
  parameter int         ACCESS_CYCLES = DEF_ACCESS_CYCLES,  // >= 2
  parameter int         PROG_CYCLES   = DEF_PROG_CYCLES,    // >= 3
  parameter logic [7:0] PROTECT_TOP   = DEF_PROTECT_TOP
) (
  input  logic              CLK_50MHZ,
  input  logic              RST,
  flash_responder_if.slave  nf,
  inout  wire  [7:0]        NF_D
);

  flash_state_e st_q, rd_st_q;
  logic [7:0]   init_cnt_q, acc_cnt_q;
  logic [15:0]  busy_cnt_q;
  logic [7:0]   a_q, d_q, dout_q;
  logic         sts_q, err_q, drv_q, status_q, we_q, ce_q;

  logic         strobe, rd_go, prog_ok;
  logic         mem_we;
  logic [7:0]   mem_addr, mem_wdata, mem_rdata;
  logic [7:0]   d_live, d_out;

  // Byte-mode only: the width select pin has no effect.
  logic unused_byte;
  assign unused_byte = nf.NF_BYTE;

  // WE rising with CE low on the previous cycle; CE may rise together with WE.
  assign strobe  = nf.NF_WE && !we_q && !ce_q;
  assign rd_go   = !nf.NF_CE && !nf.NF_OE && nf.NF_WE;
  assign prog_ok = (a_q > PROTECT_TOP) || nf.NF_WP;

  // Track previous CE/WE and latch address/data on every cycle WE is low.
  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      we_q <= 1'b1;
      ce_q <= 1'b1;
      a_q  <= '0;
      d_q  <= '0;
    end else begin
      we_q <= nf.NF_WE;
      ce_q <= nf.NF_CE;
      if (!nf.NF_WE) begin
        a_q <= nf.NF_A;
        d_q <= NF_D;
      end
    end
  end

  // Background FSM: erase sweep, program read-modify-write, busy timer.
  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      st_q       <= ST_INIT;
      init_cnt_q <= '0;
      busy_cnt_q <= '0;
      sts_q      <= 1'b0;
      err_q      <= 1'b0;
    end else if (nf.NF_RP) begin
      // Held in reset-wait: any program is abandoned and the sweep restarts,
      // so a half-finished program can never survive.
      st_q       <= ST_INIT;
      init_cnt_q <= '0;
      busy_cnt_q <= '0;
      sts_q      <= 1'b0;
    end else begin
      if (strobe && st_q != ST_IDLE) err_q <= 1'b1;
      case (st_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 8'd1;
          if (init_cnt_q == 8'hFF) begin
            st_q  <= ST_IDLE;
            sts_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (strobe) begin
            if (prog_ok) begin
              st_q       <= ST_PROG_RD;
              busy_cnt_q <= '0;
              sts_q      <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_PROG_RD: begin
          busy_cnt_q <= busy_cnt_q + 16'd1;
          st_q       <= ST_PROG_WR;
        end
        ST_PROG_WR: begin
          busy_cnt_q <= busy_cnt_q + 16'd1;
          st_q       <= ST_BUSY;
        end
        ST_BUSY: begin
          // Busy time is measured from PROG_RD entry, so RD/WR count too.
          if (busy_cnt_q == 16'(PROG_CYCLES - 1)) begin
            st_q  <= ST_IDLE;
            sts_q <= 1'b1;
          end else begin
            busy_cnt_q <= busy_cnt_q + 16'd1;
          end
        end
        default: st_q <= ST_INIT;
      endcase
    end
  end

  // Read channel: access delay, drive, then exactly one cycle of output hold.
  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      rd_st_q   <= ST_IDLE;
      acc_cnt_q <= '0;
      status_q  <= 1'b0;
      drv_q     <= 1'b0;
      dout_q    <= '0;
    end else if (nf.NF_RP) begin
      rd_st_q   <= ST_IDLE;
      acc_cnt_q <= '0;
      drv_q     <= 1'b0;
    end else begin
      case (rd_st_q)
        ST_IDLE: begin
          drv_q <= 1'b0;
          if (rd_go) begin
            rd_st_q   <= ST_READ_WAIT;
            acc_cnt_q <= '0;
            // A program accepted on this same edge makes this a status read.
            status_q  <= (st_q != ST_IDLE) || strobe;
          end
        end
        ST_READ_WAIT: begin
          // The IDLE detect cycle counts as the first access cycle.
          if (!rd_go) begin
            rd_st_q <= ST_IDLE;
          end else if (32'(acc_cnt_q) + 2 >= ACCESS_CYCLES) begin
            rd_st_q <= ST_READ_DRIVE;
            drv_q   <= 1'b1;
          end else begin
            acc_cnt_q <= acc_cnt_q + 8'd1;
          end
        end
        ST_READ_DRIVE: begin
          dout_q <= d_live;
          if (!rd_go) rd_st_q <= ST_HOLD;
        end
        ST_HOLD: begin
          drv_q   <= 1'b0;
          rd_st_q <= ST_IDLE;
        end
        default: rd_st_q <= ST_IDLE;
      endcase
    end
  end

  // RAM port arbitration: sweep and program own the port, otherwise NF_A reads.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = nf.NF_A;
    mem_wdata = ERASED;
    if (!nf.NF_RP) begin
      case (st_q)
        ST_INIT: begin
          mem_we   = 1'b1;
          mem_addr = init_cnt_q;
        end
        ST_PROG_RD: mem_addr = a_q;
        ST_PROG_WR: begin
          mem_we    = 1'b1;
          mem_addr  = a_q;
          mem_wdata = mem_rdata & d_q;  // programming only clears bits
        end
        default: ;
      endcase
    end
  end

  flash_mem_array u_mem (
    .clk_i   (CLK_50MHZ),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  // While driving, follow the RAM register so address changes show next cycle;
  // in HOLD replay the last driven byte.
  assign d_live = status_q ? STATUS_BUSY : mem_rdata;
  assign d_out  = (rd_st_q == ST_READ_DRIVE) ? d_live : dout_q;

  assign NF_D        = drv_q ? d_out : 8'hzz;
  assign nf.NF_STS   = sts_q;
  assign nf.prog_err = err_q;

endmodule

// File: tb/tb_flash_responder.sv
// Directed bench for flash_responder. Read tasks push the expected byte into a
// scoreboard queue; a monitor pops and compares when the DUT starts driving.
module tb_flash_responder;
  import flash_pkg::*;

  localparam int ACC  = 3;
  localparam int PROG = 16;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  flash_responder_if nf();
  wire  [7:0] NF_D;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_d  = 8'h00;
  assign NF_D = tb_oe ? tb_d : 8'hzz;

  flash_responder #(
    .ACCESS_CYCLES (ACC),
    .PROG_CYCLES   (PROG),
    .PROTECT_TOP   (8'h0F)
  ) dut (
    .CLK_50MHZ (clk),
    .RST       (rst),
    .nf        (nf),
    .NF_D      (NF_D)
  );

  int   n_pass = 0;
  int   n_tot  = 0;
  exp_t sbq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, req);
  endtask

  // Scoreboard monitor: first cycle of every drive is compared with the queue.
  logic oe_prev = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (dut.drv_q && !oe_prev) begin
      if (sbq.size() == 0) check("drive_without_read", 32'(sbq.size()), 1);
      else begin
        e = sbq.pop_front();
        check(e.name, {24'h0, NF_D}, {24'h0, e.val});
      end
    end
    oe_prev <= dut.drv_q;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Count negedges with NF_STS low before it rises (bounded).
  task automatic wait_ready(input int max, output int n);
    n = 0;
    @(negedge clk);
    while (!nf.NF_STS && n < max) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Called just after a posedge. CE/OE stay low until data first appears.
  task automatic do_read(input logic [7:0] a, input logic [7:0] ev, input string nm);
    exp_t e;
    int   n;
    e.name = nm;
    e.val  = ev;
    sbq.push_back(e);
    nf.NF_A  = a;
    nf.NF_CE = 1'b0;
    nf.NF_OE = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dut.drv_q && n < 20);
    check({nm, "_latency"}, n, ACC + 1);
    nf.NF_CE = 1'b1;
    nf.NF_OE = 1'b1;
    @(negedge clk);
    check({nm, "_hold_drv"}, {31'h0, dut.drv_q}, 1);
    check({nm, "_hold_val"}, {24'h0, NF_D}, {24'h0, ev});
    @(negedge clk);
    check({nm, "_released"}, {31'h0, dut.drv_q}, 0);
  endtask

  // Called just after a posedge; returns one cycle after the strobe edge.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    nf.NF_A  = a;
    tb_d     = d;
    tb_oe    = 1'b1;
    nf.NF_CE = 1'b0;
    nf.NF_WE = 1'b0;
    tick();
    nf.NF_WE = 1'b1;
    nf.NF_CE = 1'b1;
    tick();
    tb_oe = 1'b0;
  endtask

  initial begin : stim
    int   n;
    exp_t e;
    nf.NF_CE = 1'b1; nf.NF_OE = 1'b1; nf.NF_WE = 1'b1;
    nf.NF_RP = 1'b1; nf.NF_WP = 1'b1; nf.NF_BYTE = 1'b0;
    nf.NF_A  = 8'h00;
    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sts",  {31'h0, nf.NF_STS},   0);
    check("rst_err",  {31'h0, nf.prog_err}, 0);
    check("rst_bus",  {31'h0, dut.drv_q},   0);

    // Release RST but keep NF_RP high: sweep must stay frozen.
    tick(); rst = 1'b0;
    repeat (10) tick();
    check("rp_hold_sts", {31'h0, nf.NF_STS}, 0);
    nf.NF_RP = 1'b0;
    wait_ready(400, n);
    check("init_busy_cycles", n, 256);

    tick(); do_read(8'h42, 8'hFF, "rd42_erased");

    // Two programs to the same byte AND together: A5 & 3C = 24.
    tick(); do_write(8'h42, 8'hA5);
    wait_ready(100, n); check("prog1_busy_cycles", n, PROG);
    tick(); do_write(8'h42, 8'h3C);
    wait_ready(100, n); check("prog2_busy_cycles", n, PROG);
    tick(); do_read(8'h42, 8'h24, "rd42_and");

    // Protection: 0x05 rejected, 0x0F (top) rejected, 0x10 accepted.
    nf.NF_WP = 1'b0;
    tick(); do_write(8'h05, 8'h00);
    @(negedge clk);
    check("prot_err", {31'h0, nf.prog_err}, 1);
    check("prot_sts1", {31'h0, nf.NF_STS}, 1);
    @(negedge clk);
    check("prot_sts2", {31'h0, nf.NF_STS}, 1);
    tick(); do_read(8'h05, 8'hFF, "rd05_protected");
    tick(); do_write(8'h0F, 8'h00);
    @(negedge clk);
    check("prot_top_sts", {31'h0, nf.NF_STS}, 1);
    tick(); do_read(8'h0F, 8'hFF, "rd0F_protected");
    tick(); do_write(8'h10, 8'h5A);
    wait_ready(100, n); check("prog10_busy_cycles", n, PROG);
    tick(); do_read(8'h10, 8'h5A, "rd10");

    // Status read and a second write while busy.
    nf.NF_WP = 1'b1;
    tick(); do_write(8'h80, 8'hC3);
    do_read(8'h80, 8'h00, "rd_busy_status");
    tick(); do_write(8'h80, 8'h00);
    @(negedge clk);
    check("busy_write_err", {31'h0, nf.prog_err}, 1);
    wait_ready(100, n);
    check("busy_prog_done", {31'h0, nf.NF_STS}, 1);
    tick(); do_read(8'h80, 8'hC3, "rd80_first_prog");

    // NF_RP pulse mid-program while a status read is driving.
    tick(); do_write(8'h90, 8'h0F);
    e.name = "rp_status";
    e.val  = 8'h00;
    sbq.push_back(e);
    nf.NF_A = 8'h90; nf.NF_CE = 1'b0; nf.NF_OE = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dut.drv_q && n < 20);
    check("rp_status_drive", {31'h0, dut.drv_q}, 1);
    nf.NF_RP = 1'b1;
    @(negedge clk);
    check("rp_release_bus", {31'h0, dut.drv_q}, 0);
    check("rp_sts_low", {31'h0, nf.NF_STS}, 0);
    nf.NF_CE = 1'b1; nf.NF_OE = 1'b1;
    tick(); nf.NF_RP = 1'b0;
    wait_ready(400, n);
    check("rp_init_cycles", n, 256);
    tick(); do_read(8'h90, 8'hFF, "rd90_after_rp");
    tick(); do_read(8'h42, 8'hFF, "rd42_after_rp");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
